// File: rtl/button_conditioner.sv
// Input front-end for the shooter game: synchronises and debounces five push-buttons
// and turns shoot presses/holds into a frame-aligned, merge-on-pending fire request.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int AUTOFIRE_FRAMES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    input  logic       move,
    output logic [4:0] btn_level,
    output logic [4:0] btn_rise,
    output logic [3:0] press,
    output logic       fire_req,
    output logic [7:0] fire_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int               FR_W     = (AUTOFIRE_FRAMES < 2) ? 1 : $clog2(AUTOFIRE_FRAMES + 1);
    localparam logic [FR_W-1:0]  FR_WRAP  = FR_W'(AUTOFIRE_FRAMES - 1);

    typedef enum logic {IDLE, HELD} state_t;

    logic [4:0]       sync_p0;
    logic [4:0]       sync_p1;
    logic [4:0]       flip;
    logic [CNT_W-1:0] cnt [5];
    state_t           state, state_nxt;
    logic [FR_W-1:0]  frame_cnt, frame_nxt;
    logic             set_evt;

    // Two-flop synchroniser stage
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    always_comb begin
        flip = '0;
        for (int i = 0; i < 5; i++)
            flip[i] = (sync_p1[i] != btn_level[i]) && (cnt[i] == CNT_LAST);
    end

    // Debounce stage: the rise pulse is registered alongside the level it reports
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
            btn_level <= '0;
            btn_rise  <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync_p1[i] == btn_level[i] || flip[i])
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + 1'b1;
            end
            btn_level <= btn_level ^ flip;
            btn_rise  <= flip & ~btn_level;
        end
    end

    assign press = btn_level[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= frame_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        frame_nxt = frame_cnt;
        case (state)
            IDLE: begin
                if (btn_rise[4]) begin
                    state_nxt = HELD;
                    frame_nxt = '0;
                end
            end
            HELD: begin
                if (!btn_level[4]) begin
                    state_nxt = IDLE;
                    frame_nxt = '0;
                end else if (move && AUTOFIRE_FRAMES != 0) begin
                    frame_nxt = (frame_cnt == FR_WRAP) ? '0 : frame_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        set_evt = 1'b0;
        case (state)
            IDLE:    set_evt = btn_rise[4];
            HELD:    set_evt = btn_level[4] && move && (AUTOFIRE_FRAMES != 0) && (frame_cnt == FR_WRAP);
            default: set_evt = 1'b0;
        endcase
    end

    // Request stage: a set event beats a same-cycle consume; sets on a pending request merge
    always_ff @(posedge clk) begin
        if (rst) begin
            fire_req   <= 1'b0;
            fire_count <= '0;
        end else begin
            if (set_evt)
                fire_req <= 1'b1;
            else if (move && fire_req)
                fire_req <= 1'b0;
            if (set_evt && (!fire_req || move) && fire_count != 8'hFF)
                fire_count <= fire_count + 8'd1;
        end
    end

endmodule
